// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared state encoding, command-byte field positions and the
// status-byte helper for the SPI register access controller.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_CMD    = 2'd0,
    ST_WR     = 2'd1,
    ST_RD     = 2'd2,
    ST_IGNORE = 2'd3
  } state_e;

  localparam int         CMD_RW_BIT    = 7;
  localparam int         CMD_BURST_BIT = 6;
  localparam logic [3:0] STATUS_TAG    = 4'hA;
  localparam logic [7:0] STATUS_OFF    = 8'h00;

  // Tagged status byte: tag nibble, two zero bits, overrun flag, always-one LSb.
  function automatic logic [7:0] status_byte(input logic err);
    return {STATUS_TAG, 2'b00, err, 1'b1};
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: bit counter, RX/TX shift registers and byte-complete flag
// for one CS_n-bounded SPI frame. While the first byte of a frame is on the
// wire, MISO is taken straight from the status byte, which behaves exactly as
// if the TX register had been preloaded with it while CS_n was high.
module spi_byte_shifter (
  input  logic       w_SPI_Clk,
  input  logic       i_Rst_L,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  input  logic [7:0] i_Tx_Load,
  input  logic [7:0] i_Status,
  output logic       o_Byte_Done,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Tx_Bit
);

  logic       w_frame_rst_n;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx_shift;
  logic [7:0] r_tx_shift;
  logic       r_first;

  assign w_frame_rst_n = i_Rst_L & ~i_SPI_CS_n;
  assign o_Byte_Done   = (r_bit_cnt == 3'd7);
  assign o_Rx_Byte     = {r_rx_shift, i_SPI_MOSI};
  assign o_Tx_Bit      = r_first ? i_Status[~r_bit_cnt] : r_tx_shift[7];

  // RX path: shift MOSI in on every rising edge, MSb first.
  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_rx_shift <= 7'd0;
    end else begin
      r_rx_shift <= o_Rx_Byte[6:0];
    end
  end

  // Bit count and TX path; held cleared while CS_n is high so a new frame starts aligned.
  always_ff @(posedge w_SPI_Clk or negedge w_frame_rst_n) begin
    if (!w_frame_rst_n) begin
      r_bit_cnt  <= 3'd0;
      r_tx_shift <= 8'h00;
      r_first    <= 1'b1;
    end else begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
      if (o_Byte_Done) begin
        r_tx_shift <= i_Tx_Load;
        r_first    <= 1'b0;
      end else begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        r_first    <= r_first;
      end
    end
  end

endmodule

// File: rtl/spi_reg_access_ctrl.sv
// spi_reg_access_ctrl: turns SPI frames (command byte + data bytes) into
// register-file read/write strobes. Strobes are combinational at the
// byte-completing rising edge because no later SPI edge is guaranteed.
// Optional build macro SPI_REG_STATUS_EN: tagged status byte on MISO during
// the command byte, and the overrun flag clears once it has been read out.
module spi_reg_access_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         ADDR_W       = 6,
  parameter logic [7:0] RD_IDLE_BYTE = 8'h00
) (
  input  logic              w_SPI_Clk,
  input  logic              i_Rst_L,
  input  logic              i_SPI_CS_n,
  input  logic              i_SPI_MOSI,
  output wire               o_SPI_MISO,
  output logic              o_Wr_En,
  output logic [ADDR_W-1:0] o_Wr_Addr,
  output logic [7:0]        o_Wr_Data,
  output logic              o_Rd_En,
  output logic [ADDR_W-1:0] o_Rd_Addr,
  input  logic [7:0]        i_Rd_Data,
  output logic              o_Err_Overrun,
  output logic [7:0]        o_Byte_Cnt
);

  state_e            r_state;
  logic              r_burst;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_byte_cnt;
  logic              r_err_overrun;

  logic              w_frame_rst_n;
  logic              w_byte_done;
  logic [7:0]        w_rx_byte;
  logic              w_tx_bit;
  logic [7:0]        w_tx_load;
  logic [7:0]        w_status;
  logic [ADDR_W-1:0] w_addr_inc;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_frame_rst_n = i_Rst_L & ~i_SPI_CS_n;
  assign w_addr_inc    = r_addr + ADDR_W'(1);

`ifdef SPI_REG_STATUS_EN
  assign w_status = status_byte(r_err_overrun);
`else
  assign w_status = STATUS_OFF;
`endif

  spi_byte_shifter u_shifter (
    .w_SPI_Clk   (w_SPI_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_SPI_CS_n  (i_SPI_CS_n),
    .i_SPI_MOSI  (i_SPI_MOSI),
    .i_Tx_Load   (w_tx_load),
    .i_Status    (w_status),
    .o_Byte_Done (w_byte_done),
    .o_Rx_Byte   (w_rx_byte),
    .o_Tx_Bit    (w_tx_bit)
  );

  // Strobes and next TX byte, decided at the byte-completing edge.
  always_comb begin
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    w_rd_addr = r_addr;
    w_tx_load = RD_IDLE_BYTE;
    if (w_byte_done) begin
      case (r_state)
        ST_CMD: begin
          if (w_rx_byte[CMD_RW_BIT]) begin
            w_rd_en   = 1'b1;
            w_rd_addr = w_rx_byte[ADDR_W-1:0];
            w_tx_load = i_Rd_Data;
          end else begin
            w_tx_load = RD_IDLE_BYTE;
          end
        end
        ST_WR: begin
          w_wr_en = 1'b1;
        end
        ST_RD: begin
          if (r_burst) begin
            w_rd_en   = 1'b1;
            w_rd_addr = w_addr_inc;
            w_tx_load = i_Rd_Data;
          end else begin
            w_tx_load = RD_IDLE_BYTE;
          end
        end
        default: begin
          w_tx_load = RD_IDLE_BYTE;
        end
      endcase
    end else begin
      w_tx_load = RD_IDLE_BYTE;
    end
  end

  // Frame sequencing: state and saturating byte count, cleared while CS_n is high.
  always_ff @(posedge w_SPI_Clk or negedge w_frame_rst_n) begin
    if (!w_frame_rst_n) begin
      r_state    <= ST_CMD;
      r_byte_cnt <= 8'd0;
    end else if (w_byte_done) begin
      r_byte_cnt <= (r_byte_cnt == 8'hFF) ? r_byte_cnt : r_byte_cnt + 8'd1;
      case (r_state)
        ST_CMD:    r_state <= w_rx_byte[CMD_RW_BIT] ? ST_RD : ST_WR;
        ST_WR:     r_state <= r_burst ? ST_WR : ST_IGNORE;
        ST_RD:     r_state <= r_burst ? ST_RD : ST_IGNORE;
        ST_IGNORE: r_state <= ST_IGNORE;
        default:   r_state <= ST_IGNORE;
      endcase
    end else begin
      r_state    <= r_state;
      r_byte_cnt <= r_byte_cnt;
    end
  end

  // Address and burst mode: latched from the command, advanced per burst byte.
  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_addr  <= {ADDR_W{1'b0}};
      r_burst <= 1'b0;
    end else if (w_byte_done) begin
      case (r_state)
        ST_CMD: begin
          r_addr  <= w_rx_byte[ADDR_W-1:0];
          r_burst <= w_rx_byte[CMD_BURST_BIT];
        end
        ST_WR, ST_RD: begin
          r_addr  <= r_burst ? w_addr_inc : r_addr;
          r_burst <= r_burst;
        end
        default: begin
          r_addr  <= r_addr;
          r_burst <= r_burst;
        end
      endcase
    end else begin
      r_addr  <= r_addr;
      r_burst <= r_burst;
    end
  end

  // Sticky overrun flag: set by any byte completed in IGNORE; survives CS_n.
  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_err_overrun <= 1'b0;
    end else if (w_byte_done && (r_state == ST_IGNORE)) begin
      r_err_overrun <= 1'b1;
`ifdef SPI_REG_STATUS_EN
    end else if (w_byte_done && (r_state == ST_CMD)) begin
      r_err_overrun <= 1'b0;
`endif
    end else begin
      r_err_overrun <= r_err_overrun;
    end
  end

  assign o_SPI_MISO    = i_SPI_CS_n ? 1'bz : w_tx_bit;
  assign o_Wr_En       = w_wr_en;
  assign o_Wr_Addr     = r_addr;
  assign o_Wr_Data     = w_rx_byte;
  assign o_Rd_En       = w_rd_en;
  assign o_Rd_Addr     = w_rd_addr;
  assign o_Err_Overrun = r_err_overrun;
  assign o_Byte_Cnt    = r_byte_cnt;

endmodule

// File: doc/spi_reg_access_ctrl.md
Name: spi_reg_access_ctrl

Overview:
Transaction controller in the SPI clock domain that sequences slave byte transfers into register-file accesses.
- Frames a CS_n-bounded transaction as one command byte followed by data bytes.
- Issues same-edge read/write strobes to a register file and serves read data and status out on MISO.
- Owns its own RX/TX shift registers and bit counter.
- Sits between the SPI pins (polarity-corrected clock) and the register bank.

Parameters:
ADDR_W, 6, register address width (1..6); command bits [5:0] beyond ADDR_W ignored
RD_IDLE_BYTE, 8'h00, byte driven on MISO in the IGNORE state and after write data bytes

Ports:
w_SPI_Clk  in  1  SPI clock, CPOL-corrected; all sampling on rising edge
i_Rst_L  in  1  asynchronous, active-low reset
i_SPI_CS_n  in  1  chip select, active low; async clear of frame state
i_SPI_MOSI  in  1  serial data in, MSb first
o_SPI_MISO  out  1  serial data out, MSb first; Z when CS_n high
o_Wr_En  out  1  write strobe, combinational, valid at the completing rising edge
o_Wr_Addr  out  ADDR_W  write address
o_Wr_Data  out  8  write data
o_Rd_En  out  1  read strobe, combinational; register file returns i_Rd_Data in the same cycle
o_Rd_Addr  out  ADDR_W  read address
i_Rd_Data  in  8  read data, combinational from o_Rd_Addr
o_Err_Overrun  out  1  sticky: extra data byte in a non-burst frame
o_Byte_Cnt  out  8  bytes completed in current frame, saturating at 255

Behaviour:
- Reset (i_Rst_L low): state CMD, bit_cnt 0, rx_shift 0, tx_shift 0, addr 0, Byte_Cnt 0, Err_Overrun 0.
- CS_n high asynchronously clears state, bit_cnt, Byte_Cnt and tx preload.
- Err_Overrun is not cleared by CS_n; it is cleared only by i_Rst_L or by status readout.
- Command byte layout: [7] RW (1 = read), [6] BURST, [ADDR_W-1:0] address.
- Each rising edge: rx_shift <= {rx_shift[6:0], MOSI}; bit_cnt += 1 (3-bit wrap).
- Byte completes at the edge with bit_cnt == 7; the full byte is {rx_shift[6:0], MOSI}.
- MISO = tx_shift[7]; tx_shift shifts left at each edge with bit_cnt != 7 and reloads at the byte-complete edge.
- While CS_n is high, tx_shift is preloaded with the status byte so the MSb is valid before the first edge.
- States:
  - CMD: at byte complete, latch addr.
    - RW = 1: assert o_Rd_En with o_Rd_Addr = new address, load i_Rd_Data into tx_shift, go RD.
    - RW = 0: load RD_IDLE_BYTE, go WR.
  - WR: at byte complete, o_Wr_En = 1, Wr_Addr = addr, Wr_Data = completed byte.
    - BURST: addr <= addr + 1, stay WR.
    - Non-burst: go IGNORE.
  - RD:
    - BURST: at byte complete, o_Rd_En with o_Rd_Addr = addr + 1, load data, addr += 1.
    - Non-burst: go IGNORE at byte complete; no further reads.
  - IGNORE: MOSI discarded, MISO = RD_IDLE_BYTE; each completed byte sets Err_Overrun.
- Address wraps 2^ADDR_W-1 -> 0 in burst.
- Partial byte at CS_n rise is discarded; no write is issued.
- Reads are assumed side-effect free, so an abandoned prefetch is harmless.
- Strobes are purely combinational at the completing edge, because no further SPI clock edge is guaranteed after the last bit.
- Byte_Cnt increments on every completed byte, including the command byte.
- Reset during a frame returns to CMD immediately; no strobe is issued.

Optional Feature:
SPI_REG_STATUS_EN
- Defined: status byte = {4'hA, 2'b00, Err_Overrun, 1'b1}, shifted out during the command byte.
  - Err_Overrun clears at the command byte-complete edge, unless it is set in that same cycle (set wins).
- Undefined: status byte = 8'h00; Err_Overrun clears only on i_Rst_L.

Decomposition:
- Package spi_reg_pkg: state encoding (CMD, WR, RD, IGNORE), CMD_RW_BIT = 7, CMD_BURST_BIT = 6, STATUS_TAG = 4'hA.
- Sub-module spi_byte_shifter: bit counter, RX/TX shift registers, byte-complete flag, preload. The FSM, address and strobes stay at top level.

Test Plan:
- Write, non-burst: CS low, send 0x05, 0x3C -> one o_Wr_En at the 16th edge with addr 5, data 0x3C; MISO bytes 0xA1, 0x00.
- Read, burst wrap: send 0xFE, 0x00, 0x00 with regs[62] = 0x11, regs[63] = 0x22, regs[0] = 0x33 -> MISO 0xA1, 0x11, 0x22; reads at addr 62 then 63; no read of addr 0 after CS rise.
- Overrun: send 0x02, 0x55, 0x66 -> single write to addr 2; Err_Overrun = 1; next frame status byte 0xA3, then Err_Overrun clears.
- Partial byte: send 0x01, then 5 bits, then raise CS -> no o_Wr_En; Byte_Cnt = 0 after CS rise.
- Async reset mid-frame: pull i_Rst_L low after 12 edges of a write burst -> state CMD, no strobe; next 0x41, 0x77 frame writes addr 1 = 0x77.
- Macro off: repeat the overrun case -> status byte 0x00; Err_Overrun remains 1 until i_Rst_L.
